// File: rtl/mem_trace_pkg.sv
// Shared types and constants for the memory trace monitor.
package mem_trace_pkg;

  localparam int CNT_W       = 16;
  localparam int TRACE_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } trace_kind_t;

  typedef struct packed {
    trace_kind_t            kind;
    logic [TRACE_MAX_W-1:0] adr;
    logic [TRACE_MAX_W-1:0] data;
  } trace_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO: power-of-two depth, wrapping pointers, push+pop when full.
module trace_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_trace_monitor.sv
// Bus monitor: end-of-test pass/fail, event counters, trace FIFO.
// MEM_TRACE_READS_EN: also push read events into the trace.
module mem_trace_monitor
  import mem_trace_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int CHECK_ADR  = 76,
  parameter int CHECK_DATA = 7,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  input  logic             kraj,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic             trace_kind,
  output logic [WIDTH-1:0] trace_adr,
  output logic [WIDTH-1:0] trace_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             overflow,
  output logic             proto_err,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  localparam int EW = 2 * WIDTH + 1;

`ifdef MEM_TRACE_READS_EN
  localparam logic READS_EN = 1'b1;
`else
  localparam logic READS_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             ovf_q, perr_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic [31:0]      cyc_q;

  logic             run, wr_ev, rd_ev, both_ev;
  logic             push, pop, f_ovf;
  logic             adr_hit, dat_hit, to_hit;
  logic             f_full, f_empty;
  trace_kind_t      push_kind;
  logic [WIDTH-1:0] push_data;
  logic [EW-1:0]    f_din, f_dout;

  assign run     = (state_q == ST_RUN);
  assign wr_ev   = run & memwrite;
  // Simultaneous strobes are a protocol error and count as a write only.
  assign rd_ev   = run & memread & ~memwrite;
  assign both_ev = run & memread & memwrite;

  assign adr_hit = (adr == WIDTH'(CHECK_ADR));
  assign dat_hit = (writedata == WIDTH'(CHECK_DATA));
  assign to_hit  = (TIMEOUT != 0) &&
                   ((cyc_q + 32'd1) == 32'(TIMEOUT));

  assign push      = wr_ev | (READS_EN & rd_ev);
  assign pop       = trace_valid & trace_ready;
  assign f_ovf     = push & f_full & ~pop;
  assign push_kind = wr_ev ? KIND_WR : KIND_RD;
  assign push_data = wr_ev ? writedata : memdata;
  assign f_din     = {push_kind, adr, push_data};

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (f_din),
    .data_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign trace_valid = ~f_empty;
  assign trace_kind  = trace_valid & f_dout[EW-1];
  assign trace_adr   = trace_valid ? f_dout[EW-2 -: WIDTH] : '0;
  assign trace_data  = trace_valid ? f_dout[WIDTH-1:0] : '0;

  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign overflow  = ovf_q;
  assign proto_err = perr_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        // The check write outranks halt and timeout.
        if (wr_ev && adr_hit) begin
          state_d = ST_DONE;
          pass_d  = dat_hit;
          fail_d  = ~dat_hit;
        end else if (kraj || to_hit) begin
          state_d = ST_DONE;
          fail_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ovf_q    <= ovf_q | f_ovf;
      perr_q   <= perr_q | both_ev;
      wr_cnt_q <= sat_inc(wr_cnt_q, wr_ev);
      rd_cnt_q <= sat_inc(rd_cnt_q, rd_ev);
      if (run) begin
        cyc_q <= cyc_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Randomized and directed bench for mem_trace_monitor.
// Checks against a queue-based reference model.
module tb_mem_trace_monitor;
  import mem_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CADR  = 76;
  localparam int CDAT  = 7;
  localparam int TOUT  = 1000;

`ifdef MEM_TRACE_READS_EN
  localparam bit READS = 1'b1;
`else
  localparam bit READS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0, kraj = 1'b0;
  logic [7:0]  adr = '0, writedata = '0, memdata = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid, trace_kind;
  logic [7:0]  trace_adr, trace_data;
  logic        done, pass, fail, overflow, proto_err;
  logic [15:0] wr_count, rd_count;

  logic        rst2 = 1'b1;
  logic        t_valid, t_kind, t_done, t_pass, t_fail, t_ovf, t_perr;
  logic [7:0]  t_adr, t_data;
  logic [15:0] t_wr, t_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_trace_monitor dut (
    .clk(clk), .reset(reset),
    .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata),
    .kraj(kraj),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_adr(trace_adr),
    .trace_data(trace_data),
    .done(done), .pass(pass), .fail(fail),
    .overflow(overflow), .proto_err(proto_err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  mem_trace_monitor #(.TIMEOUT(20)) dut_to (
    .clk(clk), .reset(rst2),
    .memread(1'b0), .memwrite(1'b0),
    .adr(8'h00), .writedata(8'h00), .memdata(8'h00),
    .kraj(1'b0),
    .trace_valid(t_valid), .trace_ready(1'b1),
    .trace_kind(t_kind), .trace_adr(t_adr),
    .trace_data(t_data),
    .done(t_done), .pass(t_pass), .fail(t_fail),
    .overflow(t_ovf), .proto_err(t_perr),
    .wr_count(t_wr), .rd_count(t_rd)
  );

  trace_entry_t mq[$];
  bit m_started, m_fin, m_pass, m_fail, m_ovf, m_perr;
  int m_wr, m_rd, m_cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_push(input bit kd, input int a, input int d);
    trace_entry_t e;
    e.kind = kd ? KIND_WR : KIND_RD;
    e.adr  = 32'(a);
    e.data = 32'(d);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_edge(input bit rd, input bit wr, input int a,
                            input int wd, input int md,
                            input bit k, input bit rdy);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_fin) begin
      m_cyc++;
      if (wr) begin
        if (rd) m_perr = 1'b1;
        if (m_wr < 65535) m_wr++;
        m_push(1'b1, a, wd);
        if (a == CADR) begin
          m_fin = 1'b1;
          if (wd == CDAT) m_pass = 1'b1;
          else m_fail = 1'b1;
        end
      end else if (rd) begin
        if (m_rd < 65535) m_rd++;
        if (READS) m_push(1'b0, a, md);
      end
      if (!m_fin && (k || (TOUT != 0 && m_cyc == TOUT))) begin
        m_fin  = 1'b1;
        m_fail = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(trace_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("kind", 32'(trace_kind), 32'(mq[0].kind));
      check("tadr", 32'(trace_adr), mq[0].adr);
      check("tdata", 32'(trace_data), mq[0].data);
    end
    check("done", 32'(done), 32'(m_fin));
    check("pass", 32'(pass), 32'(m_pass));
    check("fail", 32'(fail), 32'(m_fail));
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("perr", 32'(proto_err), 32'(m_perr));
    check("wrcnt", 32'(wr_count), 32'(m_wr));
    check("rdcnt", 32'(rd_count), 32'(m_rd));
  endtask

  task automatic step(input bit rd, input bit wr, input int a,
                      input int wd, input int md,
                      input bit k, input bit rdy);
    memread     = rd;
    memwrite    = wr;
    adr         = 8'(a);
    writedata   = 8'(wd);
    memdata     = 8'(md);
    kraj        = k;
    trace_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(rd, wr, a & 255, wd & 255, md & 255, k, rdy);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    memread = 1'b0; memwrite = 1'b0; kraj = 1'b0;
    trace_ready = 1'b0;
    #1;
    check("rst_valid", 32'(trace_valid), 0);
    check("rst_kind", 32'(trace_kind), 0);
    check("rst_tadr", 32'(trace_adr), 0);
    check("rst_tdata", 32'(trace_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_perr", 32'(proto_err), 0);
    check("rst_wr", 32'(wr_count), 0);
    check("rst_rd", 32'(rd_count), 0);
    mq.delete();
    m_started = 0; m_fin = 0; m_pass = 0; m_fail = 0;
    m_ovf = 0; m_perr = 0; m_wr = 0; m_rd = 0; m_cyc = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pass sequence, entries drained in order.
    do_reset();
    step(0, 1, 10, 3, 0, 0, 0);
    step(0, 1, 20, 5, 0, 0, 0);
    step(0, 1, 76, 7, 0, 0, 0);
    check("p_pass", 32'(pass), 1);
    check("p_done", 32'(done), 1);
    check("p_wr", 32'(wr_count), 3);
    check("p_a0", 32'(trace_adr), 10);
    step(0, 0, 0, 0, 0, 0, 1);
    check("p_a1", 32'(trace_adr), 20);
    step(0, 0, 0, 0, 0, 0, 1);
    check("p_a2", 32'(trace_adr), 76);
    check("p_d2", 32'(trace_data), 7);
    step(0, 1, 76, 9, 0, 0, 1);
    check("p_hold", 32'(pass), 1);
    check("p_empty", 32'(trace_valid), 0);

    // Wrong data at the check address.
    do_reset();
    step(0, 1, 76, 9, 0, 0, 0);
    check("f_fail", 32'(fail), 1);
    check("f_pass", 32'(pass), 0);
    check("f_adr", 32'(trace_adr), 76);
    check("f_data", 32'(trace_data), 9);

    // Overflow: ten writes into an eight-entry FIFO.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, i + 1, 8'h30 + i, 0, 0, 0);
    check("o_ovf", 32'(overflow), 1);
    check("o_wr", 32'(wr_count), 10);
    for (int i = 0; i < 8; i++) begin
      check("o_adr", 32'(trace_adr), 32'(i + 1));
      step(0, 0, 0, 0, 0, 0, 1);
    end
    check("o_empty", 32'(trace_valid), 0);

    // Full FIFO with push and pop together keeps overflow clear.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, i + 1, i, 0, 0, 0);
    step(0, 1, 40, 41, 0, 0, 1);
    check("pp_ovf", 32'(overflow), 0);

    // Check write beats halt in the same cycle; halt alone fails.
    do_reset();
    step(0, 1, 76, 7, 0, 1, 0);
    check("k_pass", 32'(pass), 1);
    check("k_fail", 32'(fail), 0);
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    check("k_only", 32'(fail), 1);

    // Both strobes, then a plain read.
    do_reset();
    step(1, 1, 4, 8'h21, 8'h55, 0, 0);
    check("pe_perr", 32'(proto_err), 1);
    check("pe_rd", 32'(rd_count), 0);
    check("pe_kind", 32'(trace_kind), 1);
    step(1, 0, 4, 0, 8'h55, 0, 1);
    check("rd_cnt1", 32'(rd_count), 1);
    check("rd_valid", 32'(trace_valid), 32'(READS));
    if (READS) begin
      check("rd_kind", 32'(trace_kind), 0);
      check("rd_adr", 32'(trace_adr), 4);
      check("rd_data", 32'(trace_data), 8'h55);
    end

    // Reset with entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, i + 2, i, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Timeout instance: fail appears after the 21st edge.
    rst2 = 1'b0;
    #1;
    check("to_rst", 32'(t_fail), 0);
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk);
      #1;
      check("to_fail", 32'(t_fail), 32'(i >= 21));
      check("to_done", 32'(t_done), 32'(i >= 21));
    end

    // Random runs.
    for (int r = 0; r < 30; r++) begin
      int bias;
      bias = $urandom_range(0, 3);
      do_reset();
      for (int c = 0; c < 70; c++) begin
        bit rd, wr, k, rdy;
        int a, wd, md;
        rd  = ($urandom_range(0, 2) == 0);
        wr  = ($urandom_range(0, 3) == 0);
        a   = ($urandom_range(0, 5) == 0) ? CADR : $urandom_range(0, 255);
        wd  = ($urandom_range(0, 1) == 0) ? CDAT : $urandom_range(0, 255);
        md  = $urandom_range(0, 255);
        k   = ($urandom_range(0, 63) == 0);
        rdy = ($urandom_range(0, 2) < bias);
        step(rd, wr, a, wd, md, k, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_trace_monitor.md
MEM_TRACE_MONITOR -- requirements
Module: mem_trace_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address/data width.
REQ-002 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter CHECK_ADR, default 76, end-of-test write address.
REQ-004 SHALL have parameter CHECK_DATA, default 7, expected data at CHECK_ADR.
REQ-005 SHALL have parameter TIMEOUT, default 1000, cycles in RUN before fail (0 = disabled).
REQ-006 SHALL have ports: clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have ports: memread, memwrite  in  1  bus strobes; adr, writedata, memdata  in  WIDTH  bus address/write data/read data.
REQ-008 SHALL have port kraj  in  1  external halt request.
REQ-009 SHALL have ports: trace_valid  out  1; trace_ready  in  1; trace_kind  out  1 (0 read, 1 write); trace_adr, trace_data  out  WIDTH.
REQ-010 SHALL have ports: done, pass, fail, overflow, proto_err  out  1; wr_count, rd_count  out  16.

Function
REQ-011 SHALL sample all inputs on rising clk; events count only in state RUN.
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on first clk edge after reset deasserts.
REQ-013 RUN->DONE with pass=1 on write event where adr==CHECK_ADR and writedata==CHECK_DATA.
REQ-014 RUN->DONE with fail=1 on write to CHECK_ADR with other data, on kraj=1, or when TIMEOUT!=0 and cycle counter reaches TIMEOUT.
REQ-015 Pass check SHALL win over kraj/timeout in the same cycle; DONE SHALL hold until reset.
REQ-016 done, pass, fail SHALL assert registered one cycle after the terminating edge; pass and fail never both 1.
REQ-017 Write event (memwrite=1) SHALL push {1, adr, writedata} and increment wr_count.
REQ-018 Read event (memread=1) SHALL increment rd_count; trace push governed by REQ-027.
REQ-019 memread and memwrite both 1 SHALL set proto_err (sticky), treat cycle as write only, rd_count unchanged.
REQ-020 wr_count, rd_count SHALL saturate at 16'hFFFF.
REQ-021 trace_valid SHALL equal FIFO non-empty; trace_* SHALL show head entry; pop on trace_valid & trace_ready.
REQ-022 Push when full SHALL drop entry and set overflow (sticky); push and pop same cycle when full SHALL accept both, no overflow.
REQ-023 FIFO SHALL drain in DONE; terminating write SHALL be pushed like any write.
REQ-024 Pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, FIFO empty, counters 0, and trace_valid, done, pass, fail, overflow, proto_err, trace_kind, trace_adr, trace_data to 0.
REQ-026 Reset mid-RUN or mid-drain SHALL discard all FIFO contents and counts.

Configuration
REQ-027 With MEM_TRACE_READS_EN defined, read events SHALL push {0, adr, memdata}; without it reads SHALL only count, never enter FIFO.

Structure
REQ-028 Package mem_trace_pkg SHALL hold state enum, trace kind constants, trace entry struct typedef (kind, adr, data), counter width constant 16.
REQ-029 FIFO SHALL be sub-module trace_fifo (parametrised width/depth, full/empty, simultaneous push/pop).

Verification
REQ-030 Writes (10,3),(20,5),(76,7) -> pass=1, done=1, three write entries read out in order, wr_count=3.
REQ-031 Write (76,9) -> fail=1, pass=0; trace holds (76,9).
REQ-032 trace_ready=0, 10 writes, DEPTH=8 -> overflow=1, first 8 entries kept, wr_count=10.
REQ-033 kraj=1 and write (76,7) same cycle -> pass=1, fail=0; separately TIMEOUT=20 idle bus -> fail=1 at cycle 21.
REQ-034 memread=memwrite=1 at adr 4 -> proto_err=1, rd_count=0, write entry kind=1; read at 4 with memdata 0x55 -> entry (0,4,0x55) only with MEM_TRACE_READS_EN.
REQ-035 reset pulsed low mid-RUN with 3 queued entries -> trace_valid=0, counts 0, all flags 0 immediately.
